// File: rtl/predecode_queue.sv
// Fetch-bundle queue that predecodes control flow per lane at enqueue, truncates
// lanes past the first unconditional transfer, and presents the stored head entry.
module predecode_queue #(
    parameter int FETCH_WIDTH = 4,
    parameter int DEPTH       = 4,
    localparam int LANE_W     = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1,
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [63:0]              in_pc,
    input  logic [32*FETCH_WIDTH-1:0] in_insns,
    input  logic [FETCH_WIDTH-1:0]   in_mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_pc,
    output logic [32*FETCH_WIDTH-1:0] out_insns,
    output logic [4*FETCH_WIDTH-1:0] out_pd,
    output logic [FETCH_WIDTH-1:0]   out_mask,
    output logic                     out_has_cf,
    output logic [LANE_W-1:0]        out_cf_lane,
    output logic [CNT_W-1:0]         count
);

    // Handshake: a bundle moves on a rising edge when valid && ready are both high;
    // in_ready depends only on occupancy, and flush cancels both transfers that cycle.

    function automatic logic [3:0] classify(input logic [31:0] insn);
        logic [6:0] opcode;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       rd_link;
        logic       rs1_link;
        logic [3:0] cls;
        opcode   = insn[6:0];
        rd       = insn[11:7];
        rs1      = insn[19:15];
        rd_link  = (rd == 5'd1) || (rd == 5'd5);
        rs1_link = (rs1 == 5'd1) || (rs1 == 5'd5);
        cls      = 4'd0;
        case (opcode)
            7'h63: cls = 4'd1;
            7'h67: begin
                if (rd != 5'd0)    cls = 4'd6;
                else if (rs1_link) cls = 4'd2;
                else               cls = 4'd4;
            end
            7'h6f: cls = rd_link ? 4'd5 : 4'd3;
            default: cls = 4'd0;
        endcase
        return cls;
    endfunction

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [63:0]               pc_mem    [DEPTH];
    logic [32*FETCH_WIDTH-1:0] insn_mem  [DEPTH];
    logic [4*FETCH_WIDTH-1:0]  pd_mem    [DEPTH];
    logic [FETCH_WIDTH-1:0]    mask_mem  [DEPTH];
    logic                      hascf_mem [DEPTH];
    logic [LANE_W-1:0]         lane_mem  [DEPTH];

    logic [4*FETCH_WIDTH-1:0] enq_pd;
    logic [FETCH_WIDTH-1:0]   enq_mask;
    logic                     enq_has_cf;
    logic [LANE_W-1:0]        enq_cf_lane;
    logic [3:0]               cls;
    logic                     trunc;
    logic                     wr_en;
    logic                     rd_en;

    // Once an unconditional transfer is seen, every later lane is dead.
    always_comb begin
        enq_pd      = '0;
        enq_mask    = '0;
        enq_has_cf  = 1'b0;
        enq_cf_lane = '0;
        cls         = 4'd0;
        trunc       = 1'b0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            cls = in_mask[i] ? classify(in_insns[32*i +: 32]) : 4'd0;
            if (!trunc) begin
                enq_pd[4*i +: 4] = cls;
                enq_mask[i]      = in_mask[i];
                if (cls >= 4'd2) trunc = 1'b1;
            end
        end
        for (int i = FETCH_WIDTH - 1; i >= 0; i--) begin
            if (enq_pd[4*i +: 4] != 4'd0) begin
                enq_has_cf  = 1'b1;
                enq_cf_lane = LANE_W'(i);
            end
        end
    end

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign wr_en     = in_valid && in_ready && !flush && (in_mask != '0);
    assign rd_en     = out_valid && out_ready && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            insn_mem[wr_ptr_q]  <= in_insns;
            pd_mem[wr_ptr_q]    <= enq_pd;
            mask_mem[wr_ptr_q]  <= enq_mask;
            hascf_mem[wr_ptr_q] <= enq_has_cf;
            lane_mem[wr_ptr_q]  <= enq_cf_lane;
        end
    end

    // Control-flow flags are gated so an empty queue never advertises a transfer.
    assign out_pc      = pc_mem[rd_ptr_q];
    assign out_insns   = insn_mem[rd_ptr_q];
    assign out_pd      = pd_mem[rd_ptr_q];
    assign out_mask    = mask_mem[rd_ptr_q];
    assign out_has_cf  = out_valid && hascf_mem[rd_ptr_q];
    assign out_cf_lane = out_valid ? lane_mem[rd_ptr_q] : '0;
    assign count       = count_q;

endmodule

// File: tb/tb_predecode_queue.sv
// Bench for predecode_queue (FETCH_WIDTH=4, DEPTH=4): decode vectors, full/wrap,
// flush, empty-mask and asynchronous reset sequences, plus random nop traffic.
module tb_predecode_queue;

    localparam int W = 215;

    logic         clk;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_pc;
    logic [127:0] in_insns;
    logic [3:0]   in_mask;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_pc;
    logic [127:0] out_insns;
    logic [15:0]  out_pd;
    logic [3:0]   out_mask;
    logic         out_has_cf;
    logic [1:0]   out_cf_lane;
    logic [2:0]   count;

    predecode_queue #(.FETCH_WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_insns(in_insns), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_insns(out_insns), .out_pd(out_pd), .out_mask(out_mask),
        .out_has_cf(out_has_cf), .out_cf_lane(out_cf_lane), .count(count)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int            checks = 0;
    int            errors = 0;
    int            m_count = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  cur_exp;
    logic [W-1:0]  dut_rec;

    assign dut_rec = {out_pc, out_insns, out_pd, out_mask, out_has_cf, out_cf_lane};

    typedef struct {
        logic [63:0]  pc;
        logic [127:0] insns;
        logic [3:0]   mask;
        logic [15:0]  pd;
        logic [3:0]   omask;
        logic         has;
        logic [1:0]   lane;
    } vec_t;

    vec_t vecs[9];

    localparam logic [127:0] NOPS = {32'h13, 32'h13, 32'h13, 32'h13};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mk_rec(input logic [63:0] pc, input logic [127:0] insns,
                                           input logic [15:0] pd, input logic [3:0] mask,
                                           input logic has, input logic [1:0] lane);
        return {pc, insns, pd, mask, has, lane};
    endfunction

    // Reference occupancy: a full queue refuses input even when the head drains.
    always @(posedge clk or negedge reset) begin
        logic enq;
        logic deq;
        if (!reset || flush) begin
            m_count = 0;
            exp_q.delete();
        end else begin
            enq = in_valid && (m_count != 4) && (in_mask != 4'd0);
            deq = (m_count != 0) && out_ready;
            if (enq) exp_q.push_back(cur_exp);
            m_count = m_count + int'(enq) - int'(deq);
        end
    end

    // Monitor: head must match the oldest expected entry every cycle it is shown.
    always @(negedge clk) begin
        check("count", 256'(count), 256'(m_count));
        check("in_ready", 256'(in_ready), 256'(m_count != 4));
        check("out_valid", 256'(out_valid), 256'(m_count != 0));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_unexpected actual=%0h required=none", dut_rec);
            end else begin
                check("head", 256'(dut_rec), 256'(exp_q[0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end else begin
            check("idle_has_cf", 256'(out_has_cf), 256'(0));
            check("idle_cf_lane", 256'(out_cf_lane), 256'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [63:0] pc, input logic [127:0] insns,
                         input logic [3:0] mask, input logic [W-1:0] e);
        in_valid = 1'b1;
        in_pc    = pc;
        in_insns = insns;
        in_mask  = mask;
        cur_exp  = e;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_nop(input logic [63:0] pc, input logic [3:0] mask);
        drive(pc, NOPS, mask, mk_rec(pc, NOPS, 16'h0, mask, 1'b0, 2'd0));
    endtask

    initial begin
        vecs[0] = '{64'h1000, {32'h13, 32'hef, 32'h8067, 32'h63}, 4'b0011, 16'h0021, 4'b0011, 1'b1, 2'd0};
        vecs[1] = '{64'h1010, {32'h80e7, 32'h63, 32'h6f, 32'h13}, 4'b1111, 16'h0030, 4'b0011, 1'b1, 2'd1};
        vecs[2] = '{64'h1020, {32'h13, 32'h63, 32'h13, 32'h63}, 4'b1111, 16'h0101, 4'b1111, 1'b1, 2'd0};
        vecs[3] = '{64'h1030, NOPS, 4'b1111, 16'h0000, 4'b1111, 1'b0, 2'd0};
        vecs[4] = '{64'h1040, {32'h10067, 32'h13, 32'h13, 32'h13}, 4'b1111, 16'h4000, 4'b1111, 1'b1, 2'd3};
        vecs[5] = '{64'h1050, {32'h167, 32'h28067, 32'h2ef, 32'hef}, 4'b1110, 16'h0050, 4'b0010, 1'b1, 2'd1};
        vecs[6] = '{64'h1060, {32'h167, 32'h28067, 32'h63, 32'h13}, 4'b1101, 16'h0200, 4'b0101, 1'b1, 2'd2};
        vecs[7] = '{64'h1070, {32'h63, 32'h80e7, 32'h13, 32'h13}, 4'b1111, 16'h0600, 4'b0111, 1'b1, 2'd2};
        vecs[8] = '{64'h1080, {32'h13, 32'h13, 32'h13, 32'h167}, 4'b0001, 16'h0006, 4'b0001, 1'b1, 2'd0};

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_insns  = '0;
        in_mask   = '0;
        out_ready = 1'b0;
        cur_exp   = '0;
        #1 reset = 1'b0;
        #20;
        check("rst_count", 256'(count), 256'(0));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_has_cf", 256'(out_has_cf), 256'(0));
        check("rst_cf_lane", 256'(out_cf_lane), 256'(0));
        #1 reset = 1'b1;

        // Decode table; the first vector lands on the first edge after reset release.
        for (int v = 0; v < 9; v++) begin
            out_ready = 1'b0;
            drive(vecs[v].pc, vecs[v].insns, vecs[v].mask,
                  mk_rec(vecs[v].pc, vecs[v].insns, vecs[v].pd, vecs[v].omask,
                         vecs[v].has, vecs[v].lane));
            idle(2);
            out_ready = 1'b1;
            idle(1);
            out_ready = 1'b0;
        end

        // Fill past capacity, then stream through the pointer wrap.
        for (int k = 0; k < 5; k++) drive_nop(64'h2000 + 64'(k * 16), 4'b1111);
        check("full_count", 256'(count), 256'(4));
        check("full_in_ready", 256'(in_ready), 256'(0));
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) drive_nop(64'h3000 + 64'(k * 16), 4'(k + 1));
        idle(6);
        out_ready = 1'b0;

        // Flush beats a same-cycle enqueue.
        drive_nop(64'h4000, 4'b1111);
        drive_nop(64'h4010, 4'b0110);
        check("pre_flush_count", 256'(count), 256'(2));
        flush = 1'b1;
        drive_nop(64'hdead, 4'b1111);
        flush = 1'b0;
        check("flush_count", 256'(count), 256'(0));
        check("flush_out_valid", 256'(out_valid), 256'(0));
        idle(2);

        // Empty mask handshakes but stores nothing.
        drive_nop(64'h5000, 4'b0000);
        check("empty_mask_count", 256'(count), 256'(0));
        drive_nop(64'h5010, 4'b1010);
        drive_nop(64'h5020, 4'b0000);
        check("empty_mask_count2", 256'(count), 256'(1));

        // Asynchronous reset between edges with a pending handshake.
        drive_nop(64'h6000, 4'b1111);
        drive_nop(64'h6010, 4'b1111);
        check("pre_reset_count", 256'(count), 256'(3));
        in_valid = 1'b1;
        in_pc    = 64'hbad0;
        in_insns = NOPS;
        in_mask  = 4'b1111;
        #2 reset = 1'b0;
        #1;
        check("async_rst_count", 256'(count), 256'(0));
        check("async_rst_in_ready", 256'(in_ready), 256'(1));
        check("async_rst_out_valid", 256'(out_valid), 256'(0));
        in_valid = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        idle(1);

        // Random nop traffic with random masks and back-pressure.
        for (int k = 0; k < 300; k++) begin
            out_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0)
                drive_nop(64'h8000 + 64'(k * 16), 4'($urandom_range(0, 15)));
            else
                idle(1);
        end
        out_ready = 1'b1;
        idle(8);
        check("drain_count", 256'(count), 256'(0));
        check("drain_queue", 256'(exp_q.size()), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
